// File: rtl/versat_databus_responder.sv
// Slave-side responder for the Versat simple databus.
// Serves read and write bursts from a local word-addressed RAM and lets a
// test drive backpressure through stall_i.
//
// Handshake: the master raises s_valid_i and holds it, together with
// s_addr_i, s_len_i and s_wstrb_i, for the whole burst. A beat moves on
// every cycle where s_ready_o=1. s_last_o marks the final beat and is only
// ever high together with s_ready_o. Write data is sampled and read data is
// valid only on s_ready_o=1 cycles.
module versat_databus_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 20,
  parameter int MEM_ADDR_W = 10
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic                s_last_o,
  input  logic [ADDR_W-1:0]   s_addr_i,
  input  logic [DATA_W-1:0]   s_wdata_i,
  input  logic [DATA_W/8-1:0] s_wstrb_i,
  output logic [DATA_W-1:0]   s_rdata_o,
  input  logic [LEN_W-1:0]    s_len_i,
  input  logic                stall_i,
  output logic [31:0]         beats_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int DEPTH = 1 << MEM_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Current FSM state; kept as a named signal so checkers can bind to it.
  state_t state;

  logic [MEM_ADDR_W-1:0] base_q;
  logic [LEN_W:0]        n_q;
  logic [LEN_W:0]        idx_q;
  logic                  wr_q;
  logic [BYTES-1:0]      wstrb_q;
  logic [31:0]           beats_q;

  logic [DATA_W-1:0]     mem [0:DEPTH-1];
  logic [DATA_W-1:0]     rd_q;
  logic [DATA_W-1:0]     hold_q;

  logic [LEN_W:0]        len_ext;
  logic [LEN_W:0]        n_raw;
  logic [LEN_W:0]        n_next;
  logic [MEM_ADDR_W-1:0] cur_word;
  logic [MEM_ADDR_W-1:0] next_word;
  logic                  beat_ok;
  logic                  beat_last;
  logic                  unused_addr;

  // Only the word-index slice of the address is meaningful to the RAM.
  assign unused_addr = ^s_addr_i;

  // Beat count: ceil(len/BYTES), with a zero length still moving one beat.
  assign len_ext = {1'b0, s_len_i};
  assign n_raw   = (len_ext + (LEN_W+1)'(BYTES - 1)) >> OFF_W;
  assign n_next  = (s_len_i == '0) ? (LEN_W+1)'(1) : n_raw;

  // Word addresses wrap modulo the RAM depth by truncation.
  assign cur_word  = base_q + MEM_ADDR_W'(idx_q);
  assign next_word = cur_word + MEM_ADDR_W'(1);

  // Ready is combinational so stall_i bites in the same cycle.
  assign beat_ok   = (state == BURST) && !stall_i;
  assign beat_last = beat_ok && (idx_q == n_q - (LEN_W+1)'(1));

  assign s_ready_o = beat_ok;
  assign s_last_o  = beat_last;
  assign beats_o   = beats_q;

  // Read data shows the prefetched word on a read beat and otherwise holds
  // the last word that was handed out.
  assign s_rdata_o = (beat_ok && !wr_q) ? rd_q : hold_q;

  // Burst sequencing: latch the request, one setup cycle, beats, one gap cycle.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state   <= IDLE;
      base_q  <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wstrb_q <= '0;
      beats_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid_i) begin
            base_q  <= s_addr_i[OFF_W +: MEM_ADDR_W];
            n_q     <= n_next;
            wr_q    <= |s_wstrb_i;
            wstrb_q <= s_wstrb_i;
            idx_q   <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          state <= BURST;
        end
        BURST: begin
          if (beat_ok) begin
            idx_q   <= idx_q + (LEN_W+1)'(1);
            beats_q <= beats_q + 32'd1;
            if (beat_last) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          // Valid is ignored here so a master dropping it after last
          // cannot trigger a restart.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read pipeline: first word fetched in SETUP, next word prefetched on each
  // read beat so back-to-back beats run at full rate; held across stalls.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rd_q   <= '0;
      hold_q <= '0;
    end else begin
      if (state == SETUP && !wr_q) begin
        rd_q <= mem[cur_word];
      end else if (beat_ok && !wr_q) begin
        rd_q   <= mem[next_word];
        hold_q <= rd_q;
      end
    end
  end

  // Byte-masked RAM write on each write beat; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (beat_ok && wr_q) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb_q[b]) begin
          mem[cur_word][8*b +: 8] <= s_wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_versat_databus_responder.sv
// Directed bench for versat_databus_responder: bursts with hand-computed
// expected data, ready/last patterns and beat counts.
module tb_versat_databus_responder;

  logic        clk_i;
  logic        arst_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic        s_last_o;
  logic [31:0] s_addr_i;
  logic [31:0] s_wdata_i;
  logic [3:0]  s_wstrb_i;
  logic [31:0] s_rdata_o;
  logic [19:0] s_len_i;
  logic        stall_i;
  logic [31:0] beats_o;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Per-beat data: driven on writes, expected on reads.
  logic [31:0] vec [8];

  versat_databus_responder #(
    .ADDR_W(32), .DATA_W(32), .LEN_W(20), .MEM_ADDR_W(10)
  ) dut (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_last_o  (s_last_o),
    .s_addr_i  (s_addr_i),
    .s_wdata_i (s_wdata_i),
    .s_wstrb_i (s_wstrb_i),
    .s_rdata_o (s_rdata_o),
    .s_len_i   (s_len_i),
    .stall_i   (stall_i),
    .beats_o   (beats_o)
  );

  // Clock
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drive one burst from its valid cycle (cycle 0) through the DONE gap.
  // stall_mask bit c raises stall_i on cycle c counted from valid.
  task automatic run_burst(input logic [31:0] addr, input logic [19:0] len,
                           input logic [3:0] wstrb, input int nbeats,
                           input logic [15:0] stall_mask);
    int  beat;
    bit  exp_ready;
    beat = 0;
    @(negedge clk_i);
    s_valid_i = 1'b1;
    s_addr_i  = addr;
    s_len_i   = len;
    s_wstrb_i = wstrb;
    for (int c = 0; c < 40 && beat < nbeats; c++) begin
      if (c > 0) @(negedge clk_i);
      stall_i   = (c < 16) ? stall_mask[c[3:0]] : 1'b0;
      s_wdata_i = vec[beat[2:0]];
      #1;
      exp_ready = (c >= 2) && !stall_i;
      check($sformatf("ready_c%0d", c), 32'(s_ready_o), 32'(exp_ready));
      if (s_ready_o) begin
        if (wstrb == 4'h0) check($sformatf("rdata_b%0d", beat), s_rdata_o, vec[beat[2:0]]);
        check($sformatf("last_b%0d", beat), 32'(s_last_o), 32'(beat == nbeats - 1));
        beat++;
      end
    end
    check("beats_done", 32'(beat), 32'(nbeats));
    // DONE cycle with valid still held: no beat, no restart.
    @(negedge clk_i);
    stall_i = 1'b0;
    #1;
    check("done_ready", 32'(s_ready_o), 32'd0);
    check("done_state", 32'(dut.state), 32'd3);
    @(negedge clk_i);
    s_valid_i = 1'b0;
    #1;
    check("idle_ready", 32'(s_ready_o), 32'd0);
    check("idle_state", 32'(dut.state), 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    arst_i    = 1'b1;
    s_valid_i = 1'b0;
    s_addr_i  = '0;
    s_wdata_i = '0;
    s_wstrb_i = '0;
    s_len_i   = '0;
    stall_i   = 1'b0;
    for (int i = 0; i < 8; i++) vec[i] = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    arst_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("rst_ready", 32'(s_ready_o), 32'd0);
    check("rst_last",  32'(s_last_o),  32'd0);
    check("rst_rdata", s_rdata_o, 32'd0);
    check("rst_beats", beats_o, 32'd0);
    check("rst_state", 32'(dut.state), 32'd0);

    // Write burst, words 16..19 = 1..4
    vec[0] = 32'd1; vec[1] = 32'd2; vec[2] = 32'd3; vec[3] = 32'd4;
    run_burst(32'h40, 20'd16, 4'hF, 4, 16'h0000);
    check("wr_beats", beats_o, 32'd4);
    check("mem16", dut.mem[16], 32'd1);
    check("mem19", dut.mem[19], 32'd4);

    // Read burst back
    run_burst(32'h40, 20'd16, 4'h0, 4, 16'h0000);
    check("rd_beats", beats_o, 32'd8);

    // len=0 -> 1 beat, len=5 -> 2 beats
    run_burst(32'h40, 20'd0, 4'h0, 1, 16'h0000);
    check("len0_beats", beats_o, 32'd9);
    run_burst(32'h40, 20'd5, 4'h0, 2, 16'h0000);
    check("len5_beats", beats_o, 32'd11);

    // Backpressure on cycles 3 and 5: ready 1,0,1,0,1,1
    run_burst(32'h40, 20'd16, 4'h0, 4, 16'h0028);
    check("bp_beats", beats_o, 32'd15);

    // Wrap: seed top word and word 0, then partial-strobe write, then read
    vec[0] = 32'h55667788; vec[1] = 32'h99AA00BB;
    run_burst(32'd1023 * 4, 20'd8, 4'hF, 2, 16'h0000);
    vec[0] = 32'hAABBCCDD; vec[1] = 32'h11223344;
    run_burst(32'd1023 * 4, 20'd8, 4'h3, 2, 16'h0000);
    vec[0] = 32'h5566CCDD; vec[1] = 32'h99AA3344;
    run_burst(32'd1023 * 4, 20'd8, 4'h0, 2, 16'h0000);
    check("wrap_beats", beats_o, 32'd21);

    // Reset mid-burst: seed words 0..3, then abort a write after two beats
    vec[0] = 32'hA0; vec[1] = 32'hA1; vec[2] = 32'hA2; vec[3] = 32'hA3;
    run_burst(32'h0, 20'd16, 4'hF, 4, 16'h0000);
    check("seed_beats", beats_o, 32'd25);

    @(negedge clk_i);
    s_valid_i = 1'b1; s_addr_i = 32'h0; s_len_i = 20'd16; s_wstrb_i = 4'hF;
    s_wdata_i = 32'hB0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    check("abort_ready_b0", 32'(s_ready_o), 32'd1);
    @(negedge clk_i);
    s_wdata_i = 32'hB1;
    #1;
    check("abort_ready_b1", 32'(s_ready_o), 32'd1);
    @(negedge clk_i);
    s_wdata_i = 32'hB2;
    arst_i    = 1'b1;
    #1;
    check("abort_ready", 32'(s_ready_o), 32'd0);
    check("abort_beats", beats_o, 32'd0);
    check("abort_state", 32'(dut.state), 32'd0);
    @(negedge clk_i);
    arst_i    = 1'b0;
    s_valid_i = 1'b0;

    vec[0] = 32'hB0; vec[1] = 32'hB1; vec[2] = 32'hA2; vec[3] = 32'hA3;
    run_burst(32'h0, 20'd16, 4'h0, 4, 16'h0000);
    check("post_rst_beats", beats_o, 32'd4);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
